// File: rtl/inst_fetch_if.sv
// Fetch-side bundle: instruction-memory read port, redirect request and decode handshake.
// Handshake: a head entry transfers on any rising edge where inst_valid_o && inst_ready_i.
interface inst_fetch_if #(
    parameter int AW = 13
);
    logic [AW-1:0] imem_addr_o;
    logic [31:0]   imem_data_i;
    logic          redirect_i;
    logic [31:0]   redirect_pc_i;
    logic          inst_valid_o;
    logic          inst_ready_i;
    logic [31:0]   inst_o;
    logic [31:0]   inst_pc_o;
    logic [31:0]   fetch_count_o;

    modport master (
        output imem_addr_o, inst_valid_o, inst_o, inst_pc_o, fetch_count_o,
        input  imem_data_i, redirect_i, redirect_pc_i, inst_ready_i
    );

    modport slave (
        input  imem_addr_o, inst_valid_o, inst_o, inst_pc_o, fetch_count_o,
        output imem_data_i, redirect_i, redirect_pc_i, inst_ready_i
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch front-end: reads a combinational instruction memory each cycle
// into a small PC-tagged prefetch FIFO and hands entries to decode; redirect flushes.
module inst_fetch #(
    parameter int          DEPTH      = 8192,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    inst_fetch_if.master  bus
);
    localparam int          AW     = $clog2(DEPTH);
    localparam int          PW     = $clog2(FIFO_DEPTH);
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [PW:0] C_FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0] C_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] P_ONE = PW'(1);

    logic [31:0]   r_fpc;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic [31:0]   r_fetch_count;
    logic [31:0]   r_mem_pc   [FIFO_DEPTH];
    logic [31:0]   r_mem_inst [FIFO_DEPTH];

    logic w_valid;
    logic w_pop;
    logic w_push;
    logic w_unused_pc_lsb;

    assign w_valid         = (r_count != '0);
    assign w_pop           = w_valid && bus.inst_ready_i;
    // A full FIFO still accepts a new word when the head leaves in the same cycle.
    assign w_push          = !bus.redirect_i && ((r_count < C_FULL) || w_pop);
    assign w_unused_pc_lsb = ^bus.redirect_pc_i[1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fpc         <= RESET_PC;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_fetch_count <= '0;
        end else begin
            // The transfer completes even when a redirect flushes in the same cycle.
            if (w_pop) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (bus.redirect_i) begin
                r_fpc    <= {bus.redirect_pc_i[31:2], 2'b00};
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_fpc    <= r_fpc + 32'd4;
                    r_wr_ptr <= r_wr_ptr + P_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + P_ONE;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + C_ONE;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - C_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_fpc;
            r_mem_inst[r_wr_ptr] <= bus.imem_data_i;
        end
    end

    always_comb begin
        bus.imem_addr_o   = r_fpc[AW-1:0];
        bus.inst_valid_o  = w_valid;
        bus.fetch_count_o = r_fetch_count;
        bus.inst_o        = NOP;
        bus.inst_pc_o     = 32'h0000_0000;
        if (w_valid) begin
            bus.inst_o    = r_mem_inst[r_rd_ptr];
            bus.inst_pc_o = r_mem_pc[r_rd_ptr];
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: memory model returns 0x1000_0000 + word index; a scoreboard
// queue holds the expected {pc, word} stream and is restarted on reset and redirect.
module tb_inst_fetch;
  localparam int          DEPTH      = 8192;
  localparam int          AW         = 13;
  localparam int          FIFO_DEPTH = 2;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;

  inst_fetch_if #(.AW(AW)) bus();

  inst_fetch #(
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .bus(bus)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] addr);
    logic [31:0] idx;
    idx = 32'(addr >> 2);
    return 32'h1000_0000 + idx;
  endfunction

  always_comb bus.imem_data_i = mem_word(bus.imem_addr_o);

  // scoreboard
  logic [63:0] exp_q[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_fc;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back({exp_pc, mem_word(exp_pc[AW-1:0])});
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    exp_pc = {pc[31:2], 2'b00};
    refill();
  endtask

  // driver: one clock cycle; inputs at posedge+1, outputs sampled at negedge
  task automatic cycle(input logic ready, input logic redir, input logic [31:0] rpc,
                       output logic v);
    logic [63:0] head;
    bus.inst_ready_i  = ready;
    bus.redirect_i    = redir;
    bus.redirect_pc_i = rpc;
    @(negedge clk_i);
    v = bus.inst_valid_o;
    check("fetch_count", {32'h0, bus.fetch_count_o}, {32'h0, exp_fc});
    if (bus.inst_valid_o) begin
      head = exp_q[0];
      check("head_pc", {32'h0, bus.inst_pc_o}, {32'h0, head[63:32]});
      check("head_inst", {32'h0, bus.inst_o}, {32'h0, head[31:0]});
      if (ready) begin
        void'(exp_q.pop_front());
        exp_fc = exp_fc + 32'd1;
        refill();
      end
    end else begin
      check("empty_outputs", {bus.inst_pc_o, bus.inst_o}, {32'h0, NOP});
    end
    if (redir) restart(rpc);
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    bus.inst_ready_i  = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    rst_ni = 1'b0;
    restart(RESET_PC);
    exp_fc = 32'h0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    logic        v;
    logic [31:0] fc_before;

    bus.inst_ready_i  = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    restart(RESET_PC);
    exp_fc = 32'h0;
    #12;
    check("rst_valid", {63'h0, bus.inst_valid_o}, 64'h0);
    check("rst_inst", {32'h0, bus.inst_o}, {32'h0, NOP});
    check("rst_pc", {32'h0, bus.inst_pc_o}, 64'h0);
    check("rst_addr", {51'h0, bus.imem_addr_o}, {51'h0, RESET_PC[AW-1:0]});
    check("rst_count", {32'h0, bus.fetch_count_o}, 64'h0);

    // streaming with ready held high
    do_reset();
    cycle(1'b1, 1'b0, 32'h0, v);
    check("first_valid_c1", {63'h0, v}, 64'h0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 32'h0, v);
      check("stream_valid", {63'h0, v}, 64'h1);
    end
    check("count_after_10", {32'h0, bus.fetch_count_o}, 64'd10);

    // stall with ready low: FIFO fills, fetch PC parks at 8
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 32'h0, v);
      if (i >= 2) begin
        check("stall_addr", {51'h0, bus.imem_addr_o}, 64'h8);
        check("stall_pc", {32'h0, bus.inst_pc_o}, 64'h0);
        check("stall_valid", {63'h0, bus.inst_valid_o}, 64'h1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 32'h0, v);
      check("resume_valid", {63'h0, v}, 64'h1);
    end

    // redirect while full
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, v);
    cycle(1'b0, 1'b1, 32'h0000_0102, v);
    check("redir_n1_valid", {63'h0, bus.inst_valid_o}, 64'h0);
    check("redir_n1_addr", {51'h0, bus.imem_addr_o}, 64'h100);
    cycle(1'b1, 1'b0, 32'h0, v);
    check("redir_n1_v", {63'h0, v}, 64'h0);
    cycle(1'b1, 1'b0, 32'h0, v);
    check("redir_n2_v", {63'h0, v}, 64'h1);
    cycle(1'b1, 1'b0, 32'h0, v);

    // redirect coinciding with a pop
    fc_before = exp_fc;
    cycle(1'b1, 1'b1, 32'h0000_0200, v);
    check("redir_pop_v", {63'h0, v}, 64'h1);
    check("redir_pop_count", {32'h0, bus.fetch_count_o}, {32'h0, fc_before + 32'd1});
    cycle(1'b1, 1'b0, 32'h0, v);
    check("redir_pop_n1_v", {63'h0, v}, 64'h0);
    cycle(1'b1, 1'b0, 32'h0, v);
    check("redir_pop_n2_v", {63'h0, v}, 64'h1);

    // back-to-back redirects: last one wins
    cycle(1'b1, 1'b1, 32'h0000_0300, v);
    cycle(1'b1, 1'b1, 32'h0000_0407, v);
    cycle(1'b1, 1'b0, 32'h0, v);
    check("b2b_n1_v", {63'h0, v}, 64'h0);
    cycle(1'b1, 1'b0, 32'h0, v);
    check("b2b_n2_v", {63'h0, v}, 64'h1);

    // random ready toggling with occasional redirects
    for (int i = 0; i < 1000; i++) begin
      logic        redir;
      logic [31:0] rpc;
      redir = ($urandom_range(0, 49) == 0);
      rpc   = 32'($urandom_range(0, DEPTH - 1));
      cycle(1'($urandom_range(0, 1)), redir, rpc, v);
    end

    // asynchronous reset between edges while valid
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, v);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 32'h0, v);
    check("pre_async_valid", {63'h0, bus.inst_valid_o}, 64'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_valid", {63'h0, bus.inst_valid_o}, 64'h0);
    check("async_count", {32'h0, bus.fetch_count_o}, 64'h0);
    check("async_addr", {51'h0, bus.imem_addr_o}, {51'h0, RESET_PC[AW-1:0]});
    do_reset();
    cycle(1'b1, 1'b0, 32'h0, v);
    cycle(1'b1, 1'b0, 32'h0, v);
    check("post_async_v", {63'h0, v}, 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
